// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// Pipeline-control companion to the execute stage. Keeps a shadow copy of the
// destination-register tags for the instructions in EX, MEM and WB, and from
// those plus the ID-stage operands produces the EX forwarding selects, the
// load-use stall, the taken-branch flush and a saturating stall-cycle counter.
//
// Ports
//   clk, rst_n              core clock, synchronous active-low reset
//   id_valid                ID stage holds a real instruction
//   id_rs / id_rt           ID source register specifiers
//   id_useRs / id_useRt     ID instruction reads rs / rt
//   id_regWrite             ID instruction writes a register
//   id_writeReg             ID destination register
//   id_memRead              ID instruction is a load
//   branch_taken            EX instruction is a taken branch or jump
//   freeze                  global memory stall, whole pipeline holds
//   forwardA / forwardB     EX operand selects: 00 regfile, 01 WB, 10 MEM
//   stall                   hold PC and IF/ID, bubble into EX
//   flush                   squash IF/ID, bubble into EX
//   stall_count             saturating count of stalled cycles
module hazard_forward_unit #(
    parameter int unsigned REG_BITS  = 3,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [REG_BITS-1:0]  id_rs,
    input  logic [REG_BITS-1:0]  id_rt,
    input  logic                 id_useRs,
    input  logic                 id_useRt,
    input  logic                 id_regWrite,
    input  logic [REG_BITS-1:0]  id_writeReg,
    input  logic                 id_memRead,
    input  logic                 branch_taken,
    input  logic                 freeze,
    output logic [1:0]           forwardA,
    output logic [1:0]           forwardB,
    output logic                 stall,
    output logic                 flush,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // Full tag for the instruction in EX: it still needs its source operands.
    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] rs;
        logic [REG_BITS-1:0] rt;
        logic                use_rs;
        logic                use_rt;
        logic                reg_write;
        logic [REG_BITS-1:0] write_reg;
        logic                mem_read;
    } ex_tag_t;

    // Producer-only tag for MEM and WB: only the destination matters there.
    typedef struct packed {
        logic                valid;
        logic                reg_write;
        logic [REG_BITS-1:0] write_reg;
    } prod_tag_t;

    ex_tag_t              r_ex;
    prod_tag_t            r_mem;
    prod_tag_t            r_wb;
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    ex_tag_t              w_ex_next;
    prod_tag_t            w_ex_prod;
    logic                 w_rs_dep;
    logic                 w_rt_dep;
    logic                 w_loaduse;
    logic                 w_cnt_sat;

    // A stage produces register r if it holds a real register-writing instruction to r.
    function automatic logic f_hit(input prod_tag_t t, input logic [REG_BITS-1:0] r);
        f_hit = t.valid & t.reg_write & (t.write_reg == r);
    endfunction

    // Operand select: MEM holds the youngest producer, so it beats WB.
    function automatic logic [1:0] f_fwd_sel(input logic                use_op,
                                             input logic [REG_BITS-1:0] r,
                                             input prod_tag_t           mem,
                                             input prod_tag_t           wb);
        f_fwd_sel = FWD_NONE;
        if (use_op && f_hit(mem, r)) begin
            f_fwd_sel = FWD_MEM;
        end else if (use_op && f_hit(wb, r)) begin
            f_fwd_sel = FWD_WB;
        end
    endfunction

    // Forwarding selects for the instruction currently in EX.
    always_comb begin
        forwardA = f_fwd_sel(r_ex.valid & r_ex.use_rs, r_ex.rs, r_mem, r_wb);
        forwardB = f_fwd_sel(r_ex.valid & r_ex.use_rt, r_ex.rt, r_mem, r_wb);
    end

    // Load-use detection and flush; flush wins since the ID instruction dies anyway.
    always_comb begin
        w_rs_dep  = id_useRs & (r_ex.write_reg == id_rs);
        w_rt_dep  = id_useRt & (r_ex.write_reg == id_rt);
        w_loaduse = id_valid & r_ex.valid & r_ex.mem_read & r_ex.reg_write
                  & (w_rs_dep | w_rt_dep);
        flush     = r_ex.valid & branch_taken;
        stall     = w_loaduse & ~flush;
    end

    // Next EX tag: a bubble on stall or flush, otherwise the ID instruction.
    always_comb begin
        w_ex_next = '0;
        if (!(stall || flush)) begin
            w_ex_next.valid     = id_valid;
            w_ex_next.rs        = id_rs;
            w_ex_next.rt        = id_rt;
            w_ex_next.use_rs    = id_useRs;
            w_ex_next.use_rt    = id_useRt;
            w_ex_next.reg_write = id_regWrite;
            w_ex_next.write_reg = id_writeReg;
            w_ex_next.mem_read  = id_memRead;
        end
    end

    // EX tag reduced to its producer fields as it moves into MEM.
    always_comb begin
        w_ex_prod           = '0;
        w_ex_prod.valid     = r_ex.valid;
        w_ex_prod.reg_write = r_ex.reg_write;
        w_ex_prod.write_reg = r_ex.write_reg;
    end

    always_comb begin
        w_cnt_sat   = &r_stall_cnt;
        stall_count = r_stall_cnt;
    end

    // Shadow pipeline and stall counter; everything holds while frozen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
            r_stall_cnt <= '0;
        end else if (!freeze) begin
            r_wb  <= r_mem;
            r_mem <= w_ex_prod;
            r_ex  <= w_ex_next;
            if (stall && !w_cnt_sat) begin
                r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: a directed vector table, a counter saturation
// sequence and a randomized run checked against an instruction-history model.
// A second instance with a 4-bit counter shares all stimulus.
module tb_hazard_forward_unit;

    typedef struct packed {
        logic       v;
        logic [2:0] rs;
        logic [2:0] rt;
        logic       urs;
        logic       urt;
        logic       rw;
        logic [2:0] wr;
        logic       mr;
    } instr_t;

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic       st;
        logic       fl;
        int         c16;
        int         c4;
    } exp_t;

    typedef struct {
        instr_t     id;
        logic       br;
        logic       frz;
        logic       rst;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       st;
        logic       fl;
        int         cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [2:0]  id_rs;
    logic [2:0]  id_rt;
    logic        id_useRs;
    logic        id_useRt;
    logic        id_regWrite;
    logic [2:0]  id_writeReg;
    logic        id_memRead;
    logic        branch_taken;
    logic        freeze;

    logic [1:0]  fa16, fb16, fa4, fb4;
    logic        st16, fl16, st4, fl4;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;

    hazard_forward_unit #(.REG_BITS(3), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_useRs(id_useRs), .id_useRt(id_useRt), .id_regWrite(id_regWrite),
        .id_writeReg(id_writeReg), .id_memRead(id_memRead), .branch_taken(branch_taken),
        .freeze(freeze), .forwardA(fa16), .forwardB(fb16), .stall(st16), .flush(fl16),
        .stall_count(cnt16)
    );

    hazard_forward_unit #(.REG_BITS(3), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_useRs(id_useRs), .id_useRt(id_useRt), .id_regWrite(id_regWrite),
        .id_writeReg(id_writeReg), .id_memRead(id_memRead), .branch_taken(branch_taken),
        .freeze(freeze), .forwardA(fa4), .forwardB(fb4), .stall(st4), .flush(fl4),
        .stall_count(cnt4)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Model: hist[0] is the instruction in EX, hist[1] in MEM, hist[2] in WB.
    instr_t hist[$];
    int     m_c16;
    int     m_c4;

    function automatic instr_t mk(logic v, logic [2:0] rs, logic [2:0] rt, logic urs,
                                  logic urt, logic rw, logic [2:0] wr, logic mr);
        instr_t x;
        x.v = v; x.rs = rs; x.rt = rt; x.urs = urs; x.urt = urt;
        x.rw = rw; x.wr = wr; x.mr = mr;
        return x;
    endfunction

    function automatic instr_t w_i(logic [2:0] r);
        return mk(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, r, 1'b0);
    endfunction

    function automatic instr_t ld_i(logic [2:0] r);
        return mk(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, r, 1'b1);
    endfunction

    function automatic instr_t rd_i(logic [2:0] rs, logic urs, logic [2:0] rt, logic urt,
                                    logic [2:0] wr);
        return mk(1'b1, rs, rt, urs, urt, 1'b1, wr, 1'b0);
    endfunction

    function automatic logic produces(instr_t x, logic [2:0] r);
        return x.v && x.rw && (x.wr == r);
    endfunction

    function automatic logic [1:0] fwd(logic use_op, logic [2:0] r);
        if (!use_op) return 2'b00;
        if (produces(hist[1], r)) return 2'b10;
        if (produces(hist[2], r)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t model_exp(instr_t id, logic br);
        exp_t   e;
        instr_t ex;
        logic   lu;
        ex    = hist[0];
        e.fa  = fwd(ex.v && ex.urs, ex.rs);
        e.fb  = fwd(ex.v && ex.urt, ex.rt);
        e.fl  = ex.v && br;
        lu    = id.v && ex.v && ex.mr && ex.rw &&
                ((id.urs && ex.wr == id.rs) || (id.urt && ex.wr == id.rt));
        e.st  = lu && !e.fl;
        e.c16 = m_c16;
        e.c4  = m_c4;
        return e;
    endfunction

    task automatic model_reset();
        hist.delete();
        repeat (3) hist.push_back('0);
        m_c16 = 0;
        m_c4  = 0;
    endtask

    task automatic model_adv(input instr_t id, input exp_t e);
        if (e.st) begin
            if (m_c16 < 65535) m_c16++;
            if (m_c4 < 15) m_c4++;
        end
        hist.push_front((e.st || e.fl) ? instr_t'('0) : id);
        void'(hist.pop_back());
    endtask

    // One clock: drive, check outputs mid-cycle, then advance the model at posedge.
    task automatic step(input string tag, input instr_t id, input logic br, input logic frz,
                        input logic rst, input logic do_chk, input logic use_tab,
                        input exp_t tab_e);
        exp_t em;
        exp_t e;
        rst_n        = ~rst;
        id_valid     = id.v;
        id_rs        = id.rs;
        id_rt        = id.rt;
        id_useRs     = id.urs;
        id_useRt     = id.urt;
        id_regWrite  = id.rw;
        id_writeReg  = id.wr;
        id_memRead   = id.mr;
        branch_taken = br;
        freeze       = frz;
        #1;
        em = model_exp(id, br);
        e  = use_tab ? tab_e : em;
        if (do_chk) begin
            chk({tag, " fwdA"},   int'(fa16),  int'(e.fa));
            chk({tag, " fwdB"},   int'(fb16),  int'(e.fb));
            chk({tag, " stall"},  int'(st16),  int'(e.st));
            chk({tag, " flush"},  int'(fl16),  int'(e.fl));
            chk({tag, " cnt16"},  int'(cnt16), e.c16);
            chk({tag, " fwdA4"},  int'(fa4),   int'(e.fa));
            chk({tag, " fwdB4"},  int'(fb4),   int'(e.fb));
            chk({tag, " stall4"}, int'(st4),   int'(e.st));
            chk({tag, " flush4"}, int'(fl4),   int'(e.fl));
            chk({tag, " cnt4"},   int'(cnt4),  e.c4);
        end
        @(posedge clk);
        if (rst) model_reset();
        else if (!frz) model_adv(id, em);
        @(negedge clk);
    endtask

    function automatic vec_t vr(instr_t id, logic br, logic frz, logic rst, logic [1:0] fa,
                                logic [1:0] fb, logic st, logic fl, int cnt);
        vec_t x;
        x.id = id; x.br = br; x.frz = frz; x.rst = rst;
        x.fa = fa; x.fb = fb; x.st = st; x.fl = fl; x.cnt = cnt;
        return x;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t   tab[33];
        exp_t   te;
        instr_t nop;
        instr_t ri;
        logic   rbr, rfrz, rrst;

        nop = '0;
        te  = '0;
        model_reset();

        // Back-to-back RAW
        tab[0]  = vr(w_i(3'd3),                          1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 0);
        tab[1]  = vr(rd_i(3'd3, 1'b1, 3'd5, 1'b1, 3'd6), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 0);
        tab[2]  = vr(nop,                                1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 0);
        // Distance-2 RAW, then MEM-over-WB priority
        tab[3]  = vr(w_i(3'd2),                          1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 0);
        tab[4]  = vr(w_i(3'd7),                          1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 0);
        tab[5]  = vr(rd_i(3'd0, 1'b0, 3'd2, 1'b1, 3'd1), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 0);
        tab[6]  = vr(w_i(3'd2),                          1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 0);
        tab[7]  = vr(w_i(3'd2),                          1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 0);
        tab[8]  = vr(rd_i(3'd0, 1'b0, 3'd2, 1'b1, 3'd1), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 0);
        tab[9]  = vr(nop,                                1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 0);
        // Load-use: one stall, then WB forward
        tab[10] = vr(ld_i(3'd4),                         1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 0);
        tab[11] = vr(rd_i(3'd4, 1'b1, 3'd0, 1'b0, 3'd5), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 0);
        tab[12] = vr(rd_i(3'd4, 1'b1, 3'd0, 1'b0, 3'd5), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1);
        tab[13] = vr(nop,                                1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1);
        // Branch flush overriding load-use
        tab[14] = vr(ld_i(3'd4),                         1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1);
        tab[15] = vr(rd_i(3'd4, 1'b1, 3'd0, 1'b0, 3'd5), 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1);
        tab[16] = vr(rd_i(3'd4, 1'b1, 3'd0, 1'b0, 3'd5), 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1);
        tab[17] = vr(nop,                                1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1);
        // Freeze mid-forward
        tab[18] = vr(w_i(3'd3),                          1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1);
        tab[19] = vr(rd_i(3'd3, 1'b1, 3'd0, 1'b0, 3'd6), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1);
        tab[20] = vr(nop,                                1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1);
        tab[21] = vr(nop,                                1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1);
        tab[22] = vr(nop,                                1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1);
        tab[23] = vr(nop,                                1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1);
        // Freeze during a load-use stall
        tab[24] = vr(ld_i(3'd4),                         1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1);
        tab[25] = vr(rd_i(3'd4, 1'b1, 3'd0, 1'b0, 3'd5), 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1);
        tab[26] = vr(rd_i(3'd4, 1'b1, 3'd0, 1'b0, 3'd5), 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1);
        tab[27] = vr(rd_i(3'd4, 1'b1, 3'd0, 1'b0, 3'd5), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1);
        tab[28] = vr(rd_i(3'd4, 1'b1, 3'd0, 1'b0, 3'd5), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2);
        // Fill all stages, then reset mid-operation
        tab[29] = vr(w_i(3'd1),                          1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2);
        tab[30] = vr(rd_i(3'd1, 1'b1, 3'd5, 1'b1, 3'd6), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2);
        tab[31] = vr(nop,                                1'b0, 1'b0, 1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 2);
        tab[32] = vr(rd_i(3'd4, 1'b1, 3'd0, 1'b0, 3'd5), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 0);

        @(negedge clk);
        step("init", nop, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, te);
        step("init", nop, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, te);

        for (int i = 0; i < 33; i++) begin
            te.fa  = tab[i].fa;
            te.fb  = tab[i].fb;
            te.st  = tab[i].st;
            te.fl  = tab[i].fl;
            te.c16 = tab[i].cnt;
            te.c4  = tab[i].cnt;
            step($sformatf("row%0d", i), tab[i].id, tab[i].br, tab[i].frz, tab[i].rst,
                 1'b1, 1'b1, te);
        end

        // Counter saturation: repeated load-use pairs, one stall each
        step("sat_rst", nop, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, te);
        for (int i = 1; i <= 20; i++) begin
            step($sformatf("sat%0d_ld", i), ld_i(3'd4), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, te);
            step($sformatf("sat%0d_use", i), rd_i(3'd4, 1'b1, 3'd0, 1'b0, 3'd5),
                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, te);
            #1;
            chk($sformatf("sat%0d cnt4", i), int'(cnt4), (i < 15) ? i : 15);
            chk($sformatf("sat%0d cnt16", i), int'(cnt16), i);
        end

        // Randomized run against the model
        step("rnd_rst", nop, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, te);
        for (int i = 0; i < 1500; i++) begin
            ri.v   = ($urandom_range(3) != 0);
            ri.rs  = 3'($urandom_range(3));
            ri.rt  = 3'($urandom_range(3));
            ri.urs = 1'($urandom_range(1));
            ri.urt = 1'($urandom_range(1));
            ri.rw  = ($urandom_range(3) != 0);
            ri.wr  = 3'($urandom_range(3));
            ri.mr  = ($urandom_range(2) == 0);
            rbr    = ($urandom_range(5) == 0);
            rfrz   = ($urandom_range(7) == 0);
            rrst   = ($urandom_range(63) == 0);
            step($sformatf("rnd%0d", i), ri, rbr, rfrz, rrst, 1'b1, 1'b0, te);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
